seven_segment_mux_bcd: RTL and testbench

//  Parametrised N-digit multiplexed 7-segment driver for the board display.

---
 rtl/seven_segment_mux_bcd.sv | 161 ++++++++++++++++
 tb/tb_seven_segment_mux_bcd.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_mux_bcd.sv
// Multiplexed active-low 7-segment driver: captures a binary value, converts it to BCD with a
// one-shift-per-clock double-dabble engine, commits atomically. Option: LEADING_ZERO_BLANK_EN.
module seven_segment_mux_bcd #(
    parameter int unsigned IN_WIDTH     = 32,
    parameter int unsigned DIGITS       = 8,
    parameter int unsigned REFRESH_BITS = 18
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [IN_WIDTH-1:0] num_in,
    input  logic                load,
    input  logic [DIGITS-1:0]   dp_in,
    output logic                busy,
    output logic                ovf,
    output logic [7:0]          c_out,
    output logic [DIGITS-1:0]   an_out
);
    localparam int unsigned NIB_CALC = (IN_WIDTH * 302 + 999) / 1000 + 1;
    localparam int unsigned NIBS     = (NIB_CALC > DIGITS) ? NIB_CALC : DIGITS;
    localparam int unsigned CNT_W    = $clog2(IN_WIDTH + 1);
    localparam int unsigned IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] OVF_LIMIT = pow10(DIGITS);

    logic [1:0]              state_q, state_d;
    logic [IN_WIDTH-1:0]     shreg_q, shreg_d;
    logic [4*NIBS-1:0]       bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    ovf_pend_q, ovf_pend_d;
    logic                    ovf_q, ovf_d;
    logic [4*DIGITS-1:0]     disp_q, disp_d;
    logic [REFRESH_BITS-1:0] refresh_q;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [7:0]              c_q, c_d;
    logic [DIGITS-1:0]       an_q, an_d;
    logic [3:0]              nib;
    logic [6:0]              seg;
    logic [DIGITS-1:0]       blank;
`ifdef LEADING_ZERO_BLANK_EN
    logic                    lead;
`endif

    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < NIBS; i++)
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        ovf_d      = ovf_q;
        disp_d     = disp_q;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    state_d    = S_SHIFT;
                    shreg_d    = num_in;
                    bcd_d      = '0;
                    cnt_d      = '0;
                    ovf_pend_d = (64'(num_in) >= OVF_LIMIT);
                end
            end
            S_SHIFT: begin
                bcd_d   = {bcd_adj[4*NIBS-2:0], shreg_q[IN_WIDTH-1]};
                shreg_d = shreg_q << 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(IN_WIDTH - 1)) state_d = S_COMMIT;
            end
            S_COMMIT: begin
                disp_d  = bcd_q[4*DIGITS-1:0];
                ovf_d   = ovf_pend_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        idx_d = idx_q;
        if (&refresh_q) idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    always_comb begin
        blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
        // Walk down from the top digit; blanking stops at the first nonzero, digit 0 never blanks.
        lead = 1'b1;
        for (int unsigned k = 0; k + 1 < DIGITS; k++) begin
            lead = lead & (disp_q[4*(DIGITS-1-k) +: 4] == 4'd0);
            blank[DIGITS-1-k] = lead;
        end
`endif
        nib = disp_q[4*idx_q +: 4];
        case (nib)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h7F;
        endcase
        if (ovf_q)             seg = 7'h3F;
        else if (blank[idx_q]) seg = 7'h7F;
        c_d  = {~dp_in[idx_q], seg};
        an_d = ~(DIGITS'(1) << idx_q);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
            disp_q     <= '0;
            refresh_q  <= '0;
            idx_q      <= '0;
            c_q        <= '1;
            an_q       <= '1;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            ovf_q      <= ovf_d;
            disp_q     <= disp_d;
            refresh_q  <= refresh_q + REFRESH_BITS'(1);
            idx_q      <= idx_d;
            c_q        <= c_d;
            an_q       <= an_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign ovf    = ovf_q;
    assign c_out  = c_q;
    assign an_out = an_q;

endmodule

// File: tb/tb_seven_segment_mux_bcd.sv
// Bench for seven_segment_mux_bcd: decimal-arithmetic display model checked every cycle,
// plus directed scenarios with literal expected segment codes.
module tb_seven_segment_mux_bcd;
    localparam int unsigned IW = 32;
    localparam int unsigned ND = 8;
    localparam int unsigned RB = 2;

    logic          clk    = 1'b0;
    logic          resetn = 1'b0;
    logic          load   = 1'b0;
    logic [IW-1:0] num_in = '0;
    logic [ND-1:0] dp_in  = '0;
    logic          busy, ovf;
    logic [7:0]    c_out;
    logic [ND-1:0] an_out;

    seven_segment_mux_bcd #(
        .IN_WIDTH(IW),
        .DIGITS(ND),
        .REFRESH_BITS(RB)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .num_in(num_in),
        .load(load),
        .dp_in(dp_in),
        .busy(busy),
        .ovf(ovf),
        .c_out(c_out),
        .an_out(an_out)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // Cathode pattern for decimal position d of value val.
    function automatic logic [7:0] exp_cathode(input longint unsigned val, input bit ov,
                                               input int unsigned d, input logic dp);
        longint unsigned p = 1;
        int unsigned dig;
        for (int unsigned i = 0; i < d; i++) p = p * 10;
        dig = int'((val / p) % 10);
        if (ov) return {~dp, 7'h3F};
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0 && val < p) return {~dp, 7'h7F};
`endif
        return {~dp, seg_tbl[dig]};
    endfunction

    longint unsigned m_val = 0, m_pend = 0;
    bit              m_ovf = 0;
    int unsigned     m_busy_left = 0, m_n = 0, m_d = 0;
    logic [7:0]      m_c = 8'hFF, m_an = 8'hFF;
    bit              armed = 0, checking = 1;

    initial forever begin
        @(posedge clk);
        if (!resetn) begin
            armed = 1; m_n = 0; m_busy_left = 0; m_val = 0; m_ovf = 0;
            m_c = 8'hFF; m_an = 8'hFF;
        end else begin
            m_d  = (m_n / (1 << RB)) % ND;
            m_an = ~(8'd1 << m_d);
            m_c  = exp_cathode(m_val, m_ovf, m_d, dp_in[m_d]);
            m_n++;
            if (m_busy_left > 0) begin
                m_busy_left--;
                if (m_busy_left == 0) begin
                    m_val = m_pend;
                    m_ovf = (m_pend >= 64'd100000000);
                end
            end else if (load) begin
                m_pend = 64'(num_in);
                m_busy_left = IW + 1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (armed && checking) begin
            check("busy", 32'(busy), 32'(m_busy_left != 0));
            check("ovf", 32'(ovf), 32'(m_ovf));
            check("an_out", 32'(an_out), 32'(m_an));
            check("c_out", 32'(c_out), 32'(m_c));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [IW-1:0] v);
        num_in = v;
        load   = 1'b1;
        tick();
        load   = 1'b0;
    endtask

    task automatic busy_width(output int unsigned w, input logic [IW-1:0] intr, input bit do_intr);
        w = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (do_intr) begin
                if (i == 5) begin num_in = intr; load = 1'b1; end
                else load = 1'b0;
            end
            if (busy) w++;
            else break;
        end
    endtask

    task automatic expect_digit(input string name, input logic [7:0] an_pat, input logic [7:0] exp_c);
        bit found = 0;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clk);
            if (an_out == an_pat) found = 1;
        end
        if (found) check(name, 32'(c_out), 32'(exp_c));
        else check({name, "_scan_timeout"}, 32'(an_out), 32'(an_pat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int unsigned w;
        logic [7:0] lead_code;
`ifdef LEADING_ZERO_BLANK_EN
        lead_code = 8'hFF;
`else
        lead_code = 8'hC0;
`endif
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_an", 32'(an_out), 32'hFF);
        check("rst_c", 32'(c_out), 32'hFF);
        tick();
        resetn = 1'b1;
        repeat (3) tick();

        do_load(32'd12345678);
        busy_width(w, '0, 1'b0);
        check("s2_busy_width", w, 32'd33);
        expect_digit("s2_d7", 8'h7F, 8'hF9);
        expect_digit("s2_d0", 8'hFE, 8'h80);

        do_load(32'd100000000);
        busy_width(w, '0, 1'b0);
        check("s3_busy_width", w, 32'd33);
        check("s3_ovf", 32'(ovf), 32'd1);
        expect_digit("s3_d5_dash", 8'hDF, 8'hBF);
        expect_digit("s3_d0_dash", 8'hFE, 8'hBF);
        do_load(32'd7);
        busy_width(w, '0, 1'b0);
        check("s3_ovf_clear", 32'(ovf), 32'd0);
        expect_digit("s3_d0_seven", 8'hFE, 8'hF8);
        expect_digit("s3_d7_lead", 8'h7F, lead_code);

        do_load(32'd87654321);
        busy_width(w, 32'd999, 1'b1);
        check("s4_busy_width", w, 32'd33);
        expect_digit("s4_d0", 8'hFE, 8'hF9);
        expect_digit("s4_d7", 8'h7F, 8'h80);

        do_load(32'd12);
        repeat (9) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        @(negedge clk);
        check("s5_busy_after_rst", 32'(busy), 32'd0);
        expect_digit("s5_d0_cleared", 8'hFE, 8'hC0);
        expect_digit("s5_d1_cleared", 8'hFD, lead_code);
        do_load(32'd2024);
        busy_width(w, '0, 1'b0);
        check("s5_busy_width", w, 32'd33);
        expect_digit("s5_d0", 8'hFE, 8'h99);
        expect_digit("s5_d3", 8'hF7, 8'hA4);

        dp_in = 8'h01;
        do_load(32'd42);
        busy_width(w, '0, 1'b0);
        expect_digit("s6_d7", 8'h7F, lead_code);
        expect_digit("s6_d2", 8'hFB, lead_code);
        expect_digit("s6_d1", 8'hFD, 8'h99);
        expect_digit("s6_d0", 8'hFE, 8'h24);
        repeat (40) tick();

        checking = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
